// File: rtl/seq_bit_encoder_pkg.sv
// Shared definitions for the sequential 8-to-3 bit encoder.
package seq_enc_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // True when exactly one bit of v is set: non-zero, and clearing the
  // lowest set bit leaves nothing behind.
  function automatic logic onehot_count_is_one(input logic [WIDTH-1:0] v);
    return (v != {WIDTH{1'b0}}) && ((v & (v - ONE_V)) == {WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/seq_bit_encoder_if.sv
// Request-in / index-out handshake bundle of the sequential bit encoder.
interface seq_bit_encoder_if
  import seq_enc_pkg::*;
();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             zero_err;

  // Environment side: supplies vectors and consumes indices.
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, zero_err
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, zero_err
  );

endinterface

// File: rtl/seq_bit_encoder_lsb_index_finder.sv
// Combinational priority encoder: index of the lowest set bit of vec.
module lsb_index_finder
  import seq_enc_pkg::*;
#(
  parameter int unsigned P_WIDTH = WIDTH,
  parameter int unsigned P_IDX_W = IDX_W
) (
  input  logic [P_WIDTH-1:0] vec_i,
  output logic [P_IDX_W-1:0] idx_o,
  output logic               any_o
);

  // Scan upward and latch the first set bit seen; higher bits cannot override it.
  always_comb begin
    logic found_s;
    found_s = 1'b0;
    idx_o   = {P_IDX_W{1'b0}};
    for (int i = 0; i < int'(P_WIDTH); i++) begin
      idx_o   = (vec_i[i] && !found_s) ? P_IDX_W'(i) : idx_o;
      found_s = found_s | vec_i[i];
    end
    any_o = found_s;
  end

endmodule

// File: rtl/seq_bit_encoder.sv
// Sequential 8-to-3 encoder: accepts a multi-hot vector and emits the index
// of every set bit, lowest first, one per output handshake.
module seq_bit_encoder
  import seq_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  seq_bit_encoder_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] pending_q;
  logic             in_ready_q;
  logic             zero_err_q;

  logic [IDX_W-1:0] lsb_idx_s;
  logic             lsb_any_s;
  logic             last_s;
  logic [WIDTH-1:0] pending_clr_d;

  lsb_index_finder #(
    .P_WIDTH (WIDTH),
    .P_IDX_W (IDX_W)
  ) u_lsb (
    .vec_i (pending_q),
    .idx_o (lsb_idx_s),
    .any_o (lsb_any_s)
  );

  // Outputs derive from registered state only; nothing from in_* reaches them.
  assign last_s        = onehot_count_is_one(pending_q);
  assign pending_clr_d = pending_q & (pending_q - ONE_V);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_idx   = lsb_idx_s;
  assign bus.out_last  = last_s;
  assign bus.zero_err  = zero_err_q;

  // Control FSM: load a vector in IDLE, retire one set bit per accepted beat in EMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= {WIDTH{1'b0}};
      in_ready_q <= 1'b0;
      zero_err_q <= 1'b0;
    end else begin
      zero_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            if (bus.in_vec != {WIDTH{1'b0}}) begin
              pending_q  <= bus.in_vec;
              state_q    <= EMIT;
              in_ready_q <= 1'b0;
            end else begin
              zero_err_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          in_ready_q <= 1'b0;
          if (bus.out_ready && lsb_any_s) begin
            pending_q <= pending_clr_d;
            if (last_s) begin
              state_q    <= IDLE;
              in_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          pending_q  <= {WIDTH{1'b0}};
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_encoder.sv
// Directed self-checking bench for seq_bit_encoder with a queue-based reference model.
module tb_seq_bit_encoder;
  import seq_enc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_bit_encoder_if bus ();

  seq_bit_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted vector becomes a queue of its set-bit indices, ascending.
  int unsigned mq[$];
  bit          m_ready = 1'b0;
  bit          m_zerr  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ready = 1'b0;
      m_zerr  = 1'b0;
    end else begin
      m_zerr = 1'b0;
      if (mq.size() == 0) begin
        if (bus.in_valid && m_ready) begin
          if (bus.in_vec == 8'h00) m_zerr = 1'b1;
          else for (int b = 0; b < 8; b++) if (bus.in_vec[b]) mq.push_back(b);
        end
      end else if (bus.out_ready) begin
        void'(mq.pop_front());
      end
      m_ready = (mq.size() == 0);
    end
  end

  // Every-cycle comparison of DUT outputs against the model, on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
      chk("rst_out_idx",   32'(bus.out_idx),   32'd0);
      chk("rst_out_last",  32'(bus.out_last),  32'd0);
      chk("rst_zero_err",  32'(bus.zero_err),  32'd0);
    end else begin
      chk("in_ready",  32'(bus.in_ready),  32'(m_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("zero_err",  32'(bus.zero_err),  32'(m_zerr));
      if (mq.size() != 0) begin
        chk("out_idx",  32'(bus.out_idx),  mq[0]);
        chk("out_last", 32'(bus.out_last), 32'(mq.size() == 1));
      end else begin
        chk("idle_out_last", 32'(bus.out_last), 32'd0);
      end
    end
  end

  // Beat log: every accepted output beat with the cycle it happened in.
  logic [3:0] beat_q[$];
  int         beat_cyc[$];
  int         cyc = 0;
  int         zerr_cnt = 0;
  int         ov_cnt = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && bus.out_valid && bus.out_ready) begin
      beat_q.push_back({bus.out_last, bus.out_idx});
      beat_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (bus.zero_err)  zerr_cnt++;
    if (bus.out_valid) ov_cnt++;
  end

  logic [3:0] exp_q[$];

  task automatic send(input logic [7:0] vec);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low expected=in_ready_high vec=%0h", vec);
    end
    bus.in_valid = 1'b1;
    bus.in_vec   = vec;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_vec   = 8'h00;
  endtask

  task automatic wait_and_check_beats(input string name, input int n);
    for (int i = 0; i < 60; i++) begin
      if (beat_q.size() >= n) break;
      @(negedge clk);
    end
    chk({name, "_count"}, 32'(beat_q.size()), 32'(n));
    for (int i = 0; i < n && i < beat_q.size(); i++)
      chk({name, "_beat"}, 32'(beat_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [7:0] dec_or;
    bus.in_valid  = 1'b0;
    bus.in_vec    = 8'h00;
    bus.out_ready = 1'b0;

    // Test 1: reset mid-burst discards the remaining idx 7.
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 chk("t1_ready_after_release", 32'(bus.in_ready), 32'd1);
    beat_q.delete(); beat_cyc.delete();
    send(8'b1010_0000);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t1_second_idx_pending", 32'(bus.out_idx), 32'd7);
    #2 rst = 1'b1;
    #1 chk("t1_out_valid_at_rst", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    exp_q = '{4'h5};
    wait_and_check_beats("t1", 1);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd1);

    // Test 2: 8'b1001_0110 -> 1,2,4,7 on consecutive cycles, last on 7.
    beat_q.delete(); beat_cyc.delete();
    send(8'b1001_0110);
    exp_q = '{4'h1, 4'h2, 4'h4, 4'hF};
    wait_and_check_beats("t2", 4);
    chk("t2_ready_next", 32'(bus.in_ready), 32'd1);
    if (beat_cyc.size() == 4)
      for (int i = 1; i < 4; i++) chk("t2_consecutive", 32'(beat_cyc[i] - beat_cyc[0]), 32'(i));

    // Test 3: single-bit vector.
    beat_q.delete(); beat_cyc.delete();
    send(8'b1000_0000);
    exp_q = '{4'hF};
    wait_and_check_beats("t3", 1);

    // Test 4: back-pressure holds idx 0, then 0 and 1 (last).
    bus.out_ready = 1'b0;
    beat_q.delete(); beat_cyc.delete();
    send(8'b0000_0011);
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_idx",   32'(bus.out_idx),   32'd0);
      chk("t4_hold_last",  32'(bus.out_last),  32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    exp_q = '{4'h0, 4'h9};
    wait_and_check_beats("t4", 2);

    // Test 5: all-zero vector pulses zero_err once and emits nothing.
    repeat (2) @(negedge clk);
    beat_q.delete(); beat_cyc.delete();
    zerr_cnt = 0;
    ov_cnt   = 0;
    send(8'h00);
    repeat (4) @(negedge clk);
    chk("t5_zero_err_pulses", 32'(zerr_cnt), 32'd1);
    chk("t5_out_valid_cycles", 32'(ov_cnt), 32'd0);
    chk("t5_beats", 32'(beat_q.size()), 32'd0);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd1);

    // Test 6: 8'hFF -> 0..7, decoded OR is 8'hFF; then 8'h01 back-to-back.
    beat_q.delete(); beat_cyc.delete();
    send(8'hFF);
    send(8'h01);
    exp_q = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF, 4'h8};
    wait_and_check_beats("t6", 9);
    dec_or = 8'h00;
    for (int i = 0; i < 8 && i < beat_q.size(); i++) dec_or = dec_or | (8'h01 << beat_q[i][2:0]);
    chk("t6_decode_or", 32'(dec_or), 32'hFF);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
